layer0_conv: RTL and testbench

Layer-0 convolution stage of the image convolution engine: reads a 64x64 image of 20-bit signed 4.16 fixed-point pixels, applies a fixed 3x3 kernel with zero padding, adds bias, rounds, applies ReLU, and streams one 19-bit non-negative result per pixel to `layer12`. Pixels are emitted in 2x2-block order so the downstream max-pool sees each pooling window contiguously. A valid/stall handshake lets `layer12` hold the stream while it writes memory.

---
 rtl/layer0_conv.sv | 168 ++++++++++++++++
 tb/tb_layer0_conv.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_conv.sv
// rtl/layer0_conv.sv - layer-0 3x3 conv + bias + ReLU, 2x2-block pixel order, valid/stall output
// Optional macro LAYER0_ROUND_EN: round half up at bit 16 instead of truncating.
module layer0_conv #(
    parameter logic [19:0] K0   = 20'h0A89E,
    parameter logic [19:0] K1   = 20'h092D5,
    parameter logic [19:0] K2   = 20'h06D43,
    parameter logic [19:0] K3   = 20'h01004,
    parameter logic [19:0] K4   = 20'hF8F71,
    parameter logic [19:0] K5   = 20'hF6E54,
    parameter logic [19:0] K6   = 20'hFA6D7,
    parameter logic [19:0] K7   = 20'hFC834,
    parameter logic [19:0] K8   = 20'hFAC19,
    parameter logic [19:0] BIAS = 20'h01310
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ready,
    output logic        o_busy,
    output logic [11:0] o_iaddr,
    input  logic [19:0] i_idata,
    output logic        o_valid,
    output logic [18:0] o_data,
    input  logic        i_stall
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EMIT, S_DONE} state_t;

    localparam logic [43:0] ACC_INIT = {{8{BIAS[19]}}, BIAS, 16'h0000};
`ifdef LAYER0_ROUND_EN
    localparam logic [43:0] ROUND_ADD = 44'h0000_0008000;
`else
    localparam logic [43:0] ROUND_ADD = 44'h0;
`endif

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic [9:0]  blk_q, blk_d;
    logic [1:0]  sub_q, sub_d;
    logic [3:0]  tap_q, tap_d;
    logic [43:0] acc_q, acc_d;
    logic [18:0] data_q, data_d;

    logic [5:0]  row, col;
    logic [1:0]  trow, tcol;
    logic [19:0] k_sel;
    logic [6:0]  nr, nc;
    logic        in_range;
    logic signed [39:0] prod;
    logic [43:0] prod_term, acc_next, sum;
    logic [18:0] result;
    logic        last_px;

    // Block index carries the upper coordinate bits, sub-pixel the lowest bit of row/col.
    assign row = {blk_q[9:5], sub_q[1]};
    assign col = {blk_q[4:0], sub_q[0]};

    always_comb begin
        trow  = 2'd2;
        tcol  = 2'd2;
        k_sel = K8;
        case (tap_q)
            4'd0: begin trow = 2'd0; tcol = 2'd0; k_sel = K0; end
            4'd1: begin trow = 2'd0; tcol = 2'd1; k_sel = K1; end
            4'd2: begin trow = 2'd0; tcol = 2'd2; k_sel = K2; end
            4'd3: begin trow = 2'd1; tcol = 2'd0; k_sel = K3; end
            4'd4: begin trow = 2'd1; tcol = 2'd1; k_sel = K4; end
            4'd5: begin trow = 2'd1; tcol = 2'd2; k_sel = K5; end
            4'd6: begin trow = 2'd2; tcol = 2'd0; k_sel = K6; end
            4'd7: begin trow = 2'd2; tcol = 2'd1; k_sel = K7; end
            default: ;
        endcase
    end

    // A neighbour outside 0..63 wraps to bit 6 set (either -1 or 64).
    assign nr       = 7'(row) + 7'(trow) - 7'd1;
    assign nc       = 7'(col) + 7'(tcol) - 7'd1;
    assign in_range = !nr[6] && !nc[6];

    assign prod      = $signed({{20{k_sel[19]}}, k_sel}) * $signed({{20{i_idata[19]}}, i_idata});
    assign prod_term = in_range ? {{4{prod[39]}}, prod} : 44'h0;
    assign acc_next  = acc_q + prod_term;
    assign sum       = acc_next + ROUND_ADD;

    always_comb begin
        result = sum[34:16];
        if (sum[43])
            result = 19'h0;
        else if (|sum[42:35])
            result = 19'h7FFFF;
    end

    assign last_px = (blk_q == 10'h3FF) && (sub_q == 2'd3);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        blk_d   = blk_q;
        sub_d   = sub_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (i_ready) begin
                    state_d = S_FETCH;
                    busy_d  = 1'b1;
                    blk_d   = 10'h0;
                    sub_d   = 2'd0;
                    tap_d   = 4'd0;
                    acc_d   = ACC_INIT;
                end
            end
            S_FETCH: begin
                if (tap_q == 4'd8) begin
                    acc_d   = sum;
                    data_d  = result;
                    tap_d   = 4'd0;
                    state_d = S_EMIT;
                end else begin
                    acc_d = acc_next;
                    tap_d = tap_q + 4'd1;
                end
            end
            S_EMIT: begin
                if (!i_stall) begin
                    if (last_px) begin
                        state_d = S_DONE;
                    end else begin
                        {blk_d, sub_d} = {blk_q, sub_q} + 12'd1;
                        acc_d   = ACC_INIT;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            blk_q   <= 10'h0;
            sub_q   <= 2'd0;
            tap_q   <= 4'd0;
            acc_q   <= 44'h0;
            data_q  <= 19'h0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            blk_q   <= blk_d;
            sub_q   <= sub_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
        end
    end

    assign o_busy  = busy_q;
    assign o_valid = (state_q == S_EMIT);
    assign o_data  = data_q;
    assign o_iaddr = (state_q == S_FETCH && in_range) ? {nr[5:0], nc[5:0]} : 12'h0;

endmodule

// File: tb/tb_layer0_conv.sv
// tb/tb_layer0_conv.sv - self-checking bench for layer0_conv against a behavioural convolution model
module tb_layer0_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_ready;
    logic        i_stall = 1'b0;
    logic        o_busy;
    logic        o_valid;
    logic [11:0] o_iaddr;
    logic [19:0] i_idata;
    logic [18:0] o_data;

    always #5 clk = ~clk;

    logic [19:0] img [0:4095];
    assign i_idata = img[o_iaddr];

    layer0_conv dut (
        .clk     (clk),
        .reset   (rst_n),
        .i_ready (i_ready),
        .o_busy  (o_busy),
        .o_iaddr (o_iaddr),
        .i_idata (i_idata),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_stall (i_stall)
    );

    localparam logic [19:0] KT [0:8] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                                         20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};
    localparam int EXP_ADDR [0:8] = '{0, 0, 0, 0, 0, 1, 0, 64, 65};

    int n_checks = 0;
    int n_errors = 0;
    int order [0:4095];
    int idx = 0;
    int stall_mode = 0;
    logic stall_force = 1'b0;

    function automatic longint sx20(logic [19:0] v);
        return v[19] ? longint'(v) - 64'sd1048576 : longint'(v);
    endfunction

    // Direct convolution over the image array with plain integer arithmetic.
    function automatic logic [18:0] model(int r, int c);
        longint acc;
        int nr, nc;
        acc = sx20(20'h01310) * 65536;
        for (int t = 0; t < 9; t++) begin
            nr = r + t / 3 - 1;
            nc = c + t % 3 - 1;
            if (nr >= 0 && nr < 64 && nc >= 0 && nc < 64)
                acc += sx20(KT[t]) * sx20(img[nr * 64 + nc]);
        end
`ifdef LAYER0_ROUND_EN
        acc += 32768;
`endif
        if (acc < 0) return 19'h0;
        if (acc >= 64'sd34359738368) return 19'h7FFFF;
        return 19'(acc / 65536);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            idx = 0;
        end else if (o_valid) begin
            chk("valid_implies_busy", longint'(o_busy), 1);
            if (idx >= 4096) begin
                chk("extra_output_index", idx, 4095);
            end else begin
                chk($sformatf("pixel_out_%0d", idx), longint'(o_data),
                    longint'(model(order[idx] / 64, order[idx] % 64)));
                if (!i_stall) idx++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (stall_mode)
            0:       i_stall = 1'b0;
            1:       i_stall = ($urandom_range(0, 3) == 0);
            default: i_stall = stall_force;
        endcase
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  longint'(o_busy), 0);
        chk({tag, "_valid"}, longint'(o_valid), 0);
        chk({tag, "_iaddr"}, longint'(o_iaddr), 0);
        chk({tag, "_data"},  longint'(o_data), 0);
    endtask

    task automatic start_frame();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
        for (int t = 0; t < 9; t++) begin
            @(negedge clk);
            chk($sformatf("iaddr_tap%0d", t), longint'(o_iaddr), EXP_ADDR[t]);
            if (t == 0) chk("busy_after_start", longint'(o_busy), 1);
        end
        chk("no_valid_during_fetch", longint'(o_valid), 0);
    endtask

    task automatic run_until(input int n);
        int guard;
        guard = 0;
        while (idx < n && guard < 30 * n + 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (idx < n) chk("run_timeout_transfers", idx, n);
    endtask

    task automatic abort_frame();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset");
    endtask

    task automatic timed_full_frame();
        int k, first, last;
        first = -1;
        last  = -1;
        k     = 9;
        start_frame();
        while (o_busy && k < 45000) begin
            @(negedge clk);
            k++;
            if (o_valid && !i_stall) begin
                if (first < 0) first = k;
                last = k;
            end
        end
        chk("first_transfer_edge", first, 10);
        chk("last_transfer_edge", last, 40960);
        chk("busy_low_cycle", k, last + 2);
        #1 chk("transfer_count", idx, 4096);
    endtask

    task automatic fill_const(input logic [19:0] v);
        for (int i = 0; i < 4096; i++) img[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
    endtask

    initial begin
        logic [18:0] held;
        int k;
        rst_n   = 1'b0;
        i_ready = 1'b0;
        k = 0;
        for (int br = 0; br < 32; br++)
            for (int bc = 0; bc < 32; bc++)
                for (int s = 0; s < 4; s++) begin
                    order[k] = (2 * br + s / 2) * 64 + (2 * bc + s % 2);
                    k++;
                end

        fill_random();
        timed_full_frame();

        fill_const(20'h0);
        chk("model_zero_image", longint'(model(0, 0)), 19'h01310);
        stall_mode = 1;
        start_frame();
        run_until(60);
        abort_frame();

        img[0] = 20'h10000;
        chk("model_impulse_p11", longint'(model(1, 1)), 19'h0BBAE);
        chk("model_impulse_p00", longint'(model(0, 0)), 19'h0);
        start_frame();
        run_until(80);
        abort_frame();

        fill_const(20'h7FFFF);
        chk("model_max_interior", longint'(model(1, 5)), 19'h0);
        start_frame();
        run_until(70);
        abort_frame();

        fill_const(20'h80000);
        chk("model_min_interior", longint'(model(1, 5)), 19'h185F8);
        start_frame();
        run_until(70);
        abort_frame();

        for (int i = 0; i < 4096; i++) img[i] = ((i / 64) % 3 == 0) ? 20'h7FFFF : 20'h80000;
        chk("model_saturate", longint'(model(1, 5)), 19'h7FFFF);
        start_frame();
        run_until(70);
        abort_frame();

        fill_random();
        stall_mode  = 2;
        stall_force = 1'b1;
        start_frame();
        @(negedge clk);
        chk("valid_despite_stall_in_fetch", longint'(o_valid), 1);
        held = o_data;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            chk("stall_valid_held", longint'(o_valid), 1);
            chk("stall_data_held", longint'(o_data), longint'(held));
            #1 chk("stall_no_transfer", idx, 0);
        end
        stall_force = 1'b0;
        @(negedge clk);
        #1 chk("single_transfer_after_release", idx, 1);
        for (int s = 0; s < 9; s++) begin
            @(negedge clk);
            chk("next_pixel_fetch_no_valid", longint'(o_valid), 0);
        end
        @(negedge clk);
        chk("next_pixel_valid", longint'(o_valid), 1);
        stall_mode = 1;
        run_until(100);
        abort_frame();

        start_frame();
        run_until(150);
        abort_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
